bus_str_mux: RTL and testbench

- Bus-to-stream serializer, the transmit side of the 8-byte packet stream protocol.
- Accepts 32-bit address/data bus writes (vld/rdy handshake) and queues them in a small FIFO.
- Emits each write as 8 consecutive bytes on a valid/ready byte stream.
- Sits at the originating end of the link; its stream output connects directly to the stream-to-bus demux on the far side.

---
 rtl/bus_str_mux_if.sv | 23 ++
 rtl/bus_str_mux.sv | 71 +++++++
 tb/tb_bus_str_mux.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_str_mux_if.sv
// Signal bundle for the serializer: 32-bit bus write side in, byte stream side out.
interface bus_str_mux_if;
    // Valid/ready: a beat transfers on a rising clk edge where valid and ready are both
    // high; the source keeps valid and payload steady until that edge.
    logic        bus_vld;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic        bus_rdy;
    logic        str_vld;
    logic [7:0]  str_bus;
    logic        str_rdy;
    logic        str_lst;

    modport master (
        output bus_vld, bus_adr, bus_dat, str_rdy,
        input  bus_rdy, str_vld, str_bus, str_lst
    );

    modport slave (
        input  bus_vld, bus_adr, bus_dat, str_rdy,
        output bus_rdy, str_vld, str_bus, str_lst
    );
endinterface

// File: rtl/bus_str_mux.sv
// Bus-to-stream serializer: queues {adr,dat} writes in a FIFO and sends each one as
// 8 bytes, least significant first, on a valid/ready byte stream.
module bus_str_mux #(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    bus_str_mux_if.slave  bus_if,
    output logic [CW-1:0] occ_o
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [2:0]    byt_cnt_q, byt_cnt_d;
    logic          bus_trn, str_trn, pop;
    logic [63:0]   head;

    // Both ready and valid come from occ_q only, so nothing on str_rdy reaches bus_rdy.
    assign bus_if.bus_rdy = (occ_q != FULL);
    assign bus_if.str_vld = (occ_q != '0);
    assign head           = mem_q[rd_ptr_q];
    assign bus_if.str_bus = head[{byt_cnt_q, 3'b000} +: 8];
    assign bus_if.str_lst = bus_if.str_vld & (byt_cnt_q == 3'd7);
    assign occ_o          = occ_q;

    assign bus_trn = bus_if.bus_vld & bus_if.bus_rdy;
    assign str_trn = bus_if.str_vld & bus_if.str_rdy;
    assign pop     = str_trn & bus_if.str_lst;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        byt_cnt_d = byt_cnt_q;
        if (bus_trn) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (str_trn) byt_cnt_d = byt_cnt_q + 3'd1;
        case ({bus_trn, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            byt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            byt_cnt_q <= byt_cnt_d;
        end
    end

    // Packet storage carries no reset; occ_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (bus_trn) mem_q[wr_ptr_q] <= {bus_if.bus_adr, bus_if.bus_dat};
    end

    assert property (@(posedge clk) disable iff (rst) occ_q <= FULL);
endmodule

// File: tb/tb_bus_str_mux.sv
// Bench for bus_str_mux: DEPTH=1,2,3 instances, byte and packet scoreboards driven by a queue model.
module tb_bus_str_mux;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        b_vld [ND];
    logic [31:0] b_adr [ND];
    logic [31:0] b_dat [ND];
    logic        s_rdy [ND];
    logic        b_rdy [ND];
    logic        s_vld [ND];
    logic [7:0]  s_bus [ND];
    logic        s_lst [ND];
    logic [1:0]  occ   [ND];

    for (genvar k = 0; k < ND; k++) begin : g_dut
        localparam int DK = k + 1;
        logic [$clog2(DK + 1)-1:0] occ_w;
        bus_str_mux_if bif ();
        assign bif.bus_vld = b_vld[k];
        assign bif.bus_adr = b_adr[k];
        assign bif.bus_dat = b_dat[k];
        assign bif.str_rdy = s_rdy[k];
        assign b_rdy[k]    = bif.bus_rdy;
        assign s_vld[k]    = bif.str_vld;
        assign s_bus[k]    = bif.str_bus;
        assign s_lst[k]    = bif.str_lst;
        assign occ[k]      = 2'(occ_w);
        bus_str_mux #(.DEPTH(DK)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .bus_if(bif),
            .occ_o (occ_w)
        );
    end

    int cnt_cmp = 0;
    int cnt_err = 0;
    int cur_d   = 1;
    int depth   = 2;
    int m_occ   = 0;
    logic [7:0]  exp_q [$];
    logic [63:0] pkt_q [$];
    logic        last_push, last_send;
    logic        o_vld, o_rdy, o_lst;
    logic [7:0]  o_bus;
    logic [1:0]  o_occ;

    task automatic tick();
        @(negedge clk);
        o_vld = s_vld[cur_d];
        o_rdy = b_rdy[cur_d];
        o_lst = s_lst[cur_d];
        o_bus = s_bus[cur_d];
        o_occ = occ[cur_d];
    endtask

    // Drive inputs for the coming edge and advance the model by the transfers it implies.
    task automatic commit(input logic vld, input logic [31:0] adr, input logic [31:0] dat,
                          input logic rdy);
        logic [63:0] pkt;
        logic [7:0]  drop;
        last_push = vld && (m_occ != depth);
        last_send = rdy && (m_occ != 0);
        b_vld[cur_d] = vld;
        b_adr[cur_d] = adr;
        b_dat[cur_d] = dat;
        s_rdy[cur_d] = rdy;
        if (last_send) begin
            if (exp_q.size() % 8 == 1) m_occ--;
            drop = exp_q.pop_front();
        end
        if (last_push) begin
            pkt = {adr, dat};
            for (int k = 0; k < 8; k++) exp_q.push_back(pkt[8*k +: 8]);
            pkt_q.push_back(pkt);
            m_occ++;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < ND; k++) begin
            b_vld[k] = 1'b0;
            b_adr[k] = '0;
            b_dat[k] = '0;
            s_rdy[k] = 1'b0;
        end
    endtask

    task automatic do_reset(input int d);
        cur_d = d;
        depth = d + 1;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        pkt_q.delete();
        m_occ = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            cnt_cmp++;
            if (s_vld[k] !== 1'b0 || s_lst[k] !== 1'b0 || b_rdy[k] !== 1'b1 || occ[k] !== 2'd0) begin
                cnt_err++;
                $display("FAIL reset_hold d=%0d: vld=%b lst=%b rdy=%b occ=%0d, want 0 0 1 0",
                         k + 1, s_vld[k], s_lst[k], b_rdy[k], occ[k]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            cnt_cmp++;
            if (s_vld[k] !== 1'b0 || s_lst[k] !== 1'b0 || b_rdy[k] !== 1'b1 || occ[k] !== 2'd0) begin
                cnt_err++;
                $display("FAIL reset_release d=%0d: vld=%b lst=%b rdy=%b occ=%0d, want 0 0 1 0",
                         k + 1, s_vld[k], s_lst[k], b_rdy[k], occ[k]);
            end
        end
    endtask

    // want holds the expected wire bytes in send order, first byte in bits 63:56.
    task automatic test_single(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [63:0] want, input bit do_rst);
        if (do_rst) do_reset(1);
        tick();
        commit(1'b1, adr, dat, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            cnt_cmp++;
            if (c < 8) begin
                if (o_vld !== 1'b1 || o_bus !== want[63-8*c -: 8] || o_lst !== (c == 7)) begin
                    cnt_err++;
                    $display("FAIL single_byte%0d: vld=%b byte=%h lst=%b, want 1 %h %b",
                             c, o_vld, o_bus, o_lst, want[63-8*c -: 8], (c == 7));
                end
            end else if (o_vld !== 1'b0 || o_occ !== 2'd0 || o_rdy !== 1'b1) begin
                cnt_err++;
                $display("FAIL single_idle c=%0d: vld=%b occ=%0d rdy=%b, want 0 0 1",
                         c, o_vld, o_occ, o_rdy);
            end
            commit(1'b0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [63:0] src [$];
        logic [63:0] p;
        int np;
        int first_c = -1;
        int last_c  = -1;
        int exp_span;
        do_reset(d);
        np = 2 * depth + 1;
        exp_span = (depth == 1) ? np * 9 - 1 : np * 8;
        for (int i = 0; i < np; i++) src.push_back({$urandom, $urandom});
        for (int c = 0; c < 300; c++) begin
            tick();
            cnt_cmp++;
            if (o_occ !== 2'(m_occ) || o_rdy !== (m_occ != depth) || o_vld !== (m_occ != 0)) begin
                cnt_err++;
                $display("FAIL b2b_ctrl d=%0d c=%0d: occ=%0d rdy=%b vld=%b, want %0d %b %b",
                         depth, c, o_occ, o_rdy, o_vld, m_occ, (m_occ != depth), (m_occ != 0));
            end
            if (m_occ != 0) begin
                cnt_cmp++;
                if (o_bus !== exp_q[0] || o_lst !== (exp_q.size() % 8 == 1)) begin
                    cnt_err++;
                    $display("FAIL b2b_byte d=%0d c=%0d: byte=%h lst=%b, want %h %b",
                             depth, c, o_bus, o_lst, exp_q[0], (exp_q.size() % 8 == 1));
                end
            end
            if (o_vld === 1'b1) begin
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (src.size() == 0 && m_occ == 0) break;
            if (src.size() != 0) begin
                p = src[0];
                commit(1'b1, p[63:32], p[31:0], 1'b1);
                if (last_push) p = src.pop_front();
            end else begin
                commit(1'b0, '0, '0, 1'b1);
            end
        end
        cnt_cmp++;
        if (src.size() != 0 || m_occ != 0) begin
            cnt_err++;
            $display("FAIL b2b_timeout d=%0d: %0d writes and %0d packets left, want 0 0",
                     depth, src.size(), m_occ);
        end
        cnt_cmp++;
        if (last_c - first_c + 1 != exp_span) begin
            cnt_err++;
            $display("FAIL b2b_span d=%0d: str_vld span=%0d cycles, want %0d",
                     depth, last_c - first_c + 1, exp_span);
        end
    endtask

    task automatic test_backpressure(input int d, input int np);
        logic [63:0] src [$];
        logic [63:0] p;
        logic        offer = 1'b0;
        logic        rdy_in = 1'b0;
        logic        hold = 1'b0;
        logic [7:0]  prev_bus = '0;
        logic        prev_lst = 1'b0;
        do_reset(d);
        for (int i = 0; i < np; i++) src.push_back({$urandom, $urandom});
        for (int c = 0; c < 4000; c++) begin
            tick();
            cnt_cmp++;
            if (o_occ !== 2'(m_occ) || o_rdy !== (m_occ != depth) || o_vld !== (m_occ != 0)) begin
                cnt_err++;
                $display("FAIL bp_ctrl c=%0d: occ=%0d rdy=%b vld=%b, want %0d %b %b",
                         c, o_occ, o_rdy, o_vld, m_occ, (m_occ != depth), (m_occ != 0));
            end
            if (m_occ != 0) begin
                cnt_cmp++;
                if (o_bus !== exp_q[0] || o_lst !== (exp_q.size() % 8 == 1)) begin
                    cnt_err++;
                    $display("FAIL bp_byte c=%0d: byte=%h lst=%b, want %h %b",
                             c, o_bus, o_lst, exp_q[0], (exp_q.size() % 8 == 1));
                end
            end
            if (hold) begin
                cnt_cmp++;
                if (o_vld !== 1'b1 || o_bus !== prev_bus || o_lst !== prev_lst) begin
                    cnt_err++;
                    $display("FAIL bp_stable c=%0d: vld=%b byte=%h lst=%b, want 1 %h %b",
                             c, o_vld, o_bus, o_lst, prev_bus, prev_lst);
                end
            end
            if (src.size() == 0 && m_occ == 0) break;
            rdy_in = ($urandom_range(99, 0) < 50);
            offer  = (src.size() != 0) && (offer || $urandom_range(99, 0) < 70);
            p = (src.size() != 0) ? src[0] : '0;
            commit(offer, p[63:32], p[31:0], rdy_in);
            if (last_push) begin
                p = src.pop_front();
                offer = 1'b0;
            end
            hold     = o_vld && !rdy_in;
            prev_bus = o_bus;
            prev_lst = o_lst;
        end
        cnt_cmp++;
        if (src.size() != 0 || m_occ != 0) begin
            cnt_err++;
            $display("FAIL bp_timeout: %0d writes and %0d packets left, want 0 0", src.size(), m_occ);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] src [$];
        logic [63:0] p;
        int nsent = 0;
        do_reset(1);
        src.push_back({$urandom, $urandom});
        src.push_back({$urandom, $urandom});
        for (int c = 0; c < 30 && nsent < 4; c++) begin
            tick();
            p = (src.size() != 0) ? src[0] : '0;
            commit(src.size() != 0, p[63:32], p[31:0], 1'b1);
            if (last_push) p = src.pop_front();
            if (last_send) nsent++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_inputs();
        #1;
        cnt_cmp++;
        if (s_vld[1] !== 1'b0 || occ[1] !== 2'd0 || b_rdy[1] !== 1'b1 || s_lst[1] !== 1'b0) begin
            cnt_err++;
            $display("FAIL reset_mid_async: vld=%b occ=%0d rdy=%b lst=%b, want 0 0 1 0",
                     s_vld[1], occ[1], b_rdy[1], s_lst[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        pkt_q.delete();
        m_occ = 0;
        test_single(32'h0000_0001, 32'h0000_0002, 64'h0200_0000_0100_0000, 1'b0);
    endtask

    task automatic test_loopback(input int d, input int np);
        logic [63:0] rx = '0;
        logic [63:0] want;
        logic [63:0] p;
        logic        offer = 1'b0;
        int nrx = 0;
        int nsrc = 0;
        do_reset(d);
        for (int c = 0; c < 40000; c++) begin
            tick();
            cnt_cmp++;
            if (o_occ !== 2'(m_occ) || o_rdy !== (m_occ != depth) || o_vld !== (m_occ != 0)) begin
                cnt_err++;
                $display("FAIL loop_ctrl d=%0d c=%0d: occ=%0d rdy=%b vld=%b, want %0d %b %b",
                         depth, c, o_occ, o_rdy, o_vld, m_occ, (m_occ != depth), (m_occ != 0));
            end
            if (nsrc == np && m_occ == 0) break;
            if (!offer) p = {$urandom, $urandom};
            offer = (nsrc < np) && (offer || $urandom_range(99, 0) < 60);
            commit(offer, p[63:32], p[31:0], $urandom_range(99, 0) < 50);
            if (last_push) begin
                nsrc++;
                offer = 1'b0;
            end
            if (last_send) begin
                rx = {o_bus, rx[63:8]};
                nrx++;
                if (nrx % 8 == 0) begin
                    want = pkt_q.pop_front();
                    cnt_cmp++;
                    if (rx !== want) begin
                        cnt_err++;
                        $display("FAIL loop_pkt d=%0d n=%0d: got %h, want %h", depth, nrx / 8, rx, want);
                    end
                end
            end
        end
        cnt_cmp++;
        if (nrx != np * 8 || m_occ != 0) begin
            cnt_err++;
            $display("FAIL loop_count d=%0d: bytes=%0d, want %0d", depth, nrx, np * 8);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single(32'h89AB_CDEF, 32'h0123_4567, 64'h6745_2301_EFCD_AB89, 1'b1);
        test_back_to_back(1);
        test_back_to_back(0);
        test_back_to_back(2);
        test_backpressure(1, 16);
        test_reset_mid();
        test_loopback(1, 1000);
        test_loopback(2, 200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want test sequence complete");
        $fatal(1, "time limit");
    end
endmodule
